// File: rtl/pid_ctrl_pkg.sv
// Shared types and widths for the PID sample controller.
//   pid_state_e : sequencer states
//   SPD_W/OUT_W/DUTY_W : speed, PID result and PWM duty widths
//   sat_duty()  : clamps a 14-bit PID result into the 12-bit duty range
package pid_ctrl_pkg;
  localparam int SPD_W  = 12;
  localparam int OUT_W  = 14;
  localparam int DUTY_W = 12;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE, START, CLR, WAIT_END, CAPTURE, COOLDOWN
  } pid_state_e;

  function automatic logic [DUTY_W-1:0] sat_duty(input logic [OUT_W-1:0] v);
    return (|v[OUT_W-1:DUTY_W]) ? DUTY_MAX : v[DUTY_W-1:0];
  endfunction
endpackage

// File: rtl/enc_pulse_counter.sv
// Encoder pulse counter: synchronises enc_a, counts its rising edges in a
// saturating window counter and latches the count on each period tick.
//   clk, rst_n : clock, async active-low reset
//   enc_a      : asynchronous encoder input
//   tick       : period terminal-count pulse
//   spd        : edge count of the last complete window
module enc_pulse_counter
  import pid_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             tick,
  output logic [SPD_W-1:0] spd
);
  // [0],[1] form the synchroniser, [2] is the delayed copy for edge detect
  logic [2:0]       sync_q;
  logic [SPD_W-1:0] win_cnt;
  logic             rise;

  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      win_cnt <= '0;
      spd     <= '0;
    end else begin
      sync_q <= {sync_q[1:0], enc_a};
      if (tick) begin
        spd     <= win_cnt;
        // an edge landing on the tick belongs to the new window
        win_cnt <= rise ? SPD_W'(1) : '0;
      end else if (rise && win_cnt != '1) begin
        win_cnt <= win_cnt + SPD_W'(1);
      end
    end
  end
endmodule

// File: rtl/pid_sample_ctrl.sv
// Initiator side of the PID core handshake. Every control period it latches
// the encoder speed, starts the PID core, waits for PID_end and captures the
// saturated result as the PWM duty. Integrator preloads (clr_req) are
// sequenced through PID_clr, deferred while a transaction is in flight.
// Optional: define PID_DUTY_RAMP_EN to limit each duty update to MAX_STEP.
//   clk, rst_n            : clock, async active-low reset
//   enc_a                 : asynchronous encoder pulses
//   rt_set                : speed setpoint
//   clr_req, ins_data     : preload request and value
//   PID_end, PID_out      : PID core done flag and result
//   PID_start, PID_clr    : PID core start / clear strobes
//   PID_rt, PID_yt        : setpoint and measured speed to the core
//   PID_insdata           : preload value to the core
//   duty, duty_vld        : PWM duty and its update strobe
//   busy                  : sequencer not idle
//   timeout_err, overrun_err : sticky errors, cleared by clr_req
module pid_sample_ctrl
  import pid_ctrl_pkg::*;
#(
  parameter int PERIOD_CYC  = 50000,
  parameter int TIMEOUT_CYC = 64,
  parameter int MAX_STEP    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_a,
  input  logic [SPD_W-1:0]  rt_set,
  input  logic              clr_req,
  input  logic [SPD_W-1:0]  ins_data,
  input  logic              PID_end,
  input  logic [OUT_W-1:0]  PID_out,
  output logic              PID_start,
  output logic              PID_clr,
  output logic [SPD_W-1:0]  PID_rt,
  output logic [SPD_W-1:0]  PID_yt,
  output logic [SPD_W-1:0]  PID_insdata,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_vld,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun_err
);
  localparam int PW = $clog2(PERIOD_CYC);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int DW1 = DUTY_W + 1;

  pid_state_e        state;
  logic [PW-1:0]     per_cnt;
  logic              tick;
  logic [TW-1:0]     tmo_cnt;
  logic              clr_ph;     // second PID_clr cycle
  logic              clr_pend;
  logic [SPD_W-1:0]  ins_pend;
  logic              pid_end_d;
  logic [DUTY_W-1:0] duty_tgt, duty_nxt;

  assign tick = (per_cnt == PW'(PERIOD_CYC - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) per_cnt <= '0;
    else        per_cnt <= tick ? '0 : per_cnt + PW'(1);
  end

  enc_pulse_counter u_enc (
    .clk   (clk),
    .rst_n (rst_n),
    .enc_a (enc_a),
    .tick  (tick),
    .spd   (PID_yt)
  );

  assign duty_tgt = sat_duty(PID_out);

`ifdef PID_DUTY_RAMP_EN
  localparam logic [DUTY_W:0] STEP = DW1'(MAX_STEP);
  logic [DUTY_W:0] up_lim;
  always_comb begin
    up_lim = {1'b0, duty} + STEP;
    if ({1'b0, duty_tgt} > up_lim)
      duty_nxt = up_lim[DUTY_W-1:0];
    else if ({1'b0, duty_tgt} + STEP < {1'b0, duty})
      duty_nxt = duty - STEP[DUTY_W-1:0];
    else
      duty_nxt = duty_tgt;
  end
`else
  assign duty_nxt = duty_tgt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      clr_ph      <= 1'b0;
      clr_pend    <= 1'b0;
      ins_pend    <= '0;
      pid_end_d   <= 1'b0;
      PID_start   <= 1'b0;
      PID_clr     <= 1'b0;
      PID_rt      <= '0;
      PID_insdata <= '0;
      duty        <= '0;
      duty_vld    <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      pid_end_d <= PID_end;
      PID_start <= 1'b0;
      duty_vld  <= 1'b0;

      // clear first so an error raised in the same cycle survives
      if (clr_req) begin
        timeout_err <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (state != IDLE) begin
        if (tick) overrun_err <= 1'b1;
        if (clr_req) begin
          clr_pend <= 1'b1;
          ins_pend <= ins_data;
        end
      end

      case (state)
        IDLE: begin
          if (clr_pend || clr_req) begin
            state       <= CLR;
            PID_clr     <= 1'b1;
            clr_ph      <= 1'b0;
            clr_pend    <= 1'b0;
            PID_insdata <= clr_req ? ins_data : ins_pend;
            if (tick) overrun_err <= 1'b1;  // tick lost to the clear
          end else if (tick) begin
            PID_rt <= rt_set;
            if (!PID_end) state <= START;
          end
        end
        START: begin
          PID_start <= 1'b1;
          tmo_cnt   <= '0;
          state     <= WAIT_END;
        end
        CLR: begin
          if (clr_ph) begin
            PID_clr <= 1'b0;
            tmo_cnt <= '0;
            state   <= WAIT_END;
          end else begin
            clr_ph <= 1'b1;
          end
        end
        WAIT_END: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (PID_end && !pid_end_d) begin
            state <= CAPTURE;
          end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            // TIMEOUT_CYC cycles spent here without a PID_end edge
            timeout_err <= 1'b1;
            state       <= COOLDOWN;
          end
        end
        CAPTURE: begin
          duty     <= duty_nxt;
          duty_vld <= 1'b1;
          state    <= COOLDOWN;
        end
        COOLDOWN: begin
          // PID_end stays high through the core's output hold
          if (!PID_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pid_sample_ctrl.sv
module tb_pid_sample_ctrl;
  localparam int PER = 200;
  localparam int TO  = 64;
  localparam int NP  = 12;
  localparam int NC  = PER * NP + 150;
  localparam int NA  = NC + 600;
  localparam int K_NONE = 0, K_NORM = 1, K_TO = 2, K_HOLD = 3, K_COINC = 4;

  logic clk = 0, rst_n = 0, enc_a = 0, clr_req = 0, PID_end = 0;
  logic [11:0] rt_set = 0, ins_data = 0;
  logic [13:0] PID_out = 0;
  logic PID_start, PID_clr, duty_vld, busy, timeout_err, overrun_err;
  logic [11:0] PID_rt, PID_yt, PID_insdata, duty;

  pid_sample_ctrl #(.PERIOD_CYC(PER), .TIMEOUT_CYC(TO), .MAX_STEP(64)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .rt_set(rt_set), .clr_req(clr_req),
    .ins_data(ins_data), .PID_end(PID_end), .PID_out(PID_out),
    .PID_start(PID_start), .PID_clr(PID_clr), .PID_rt(PID_rt), .PID_yt(PID_yt),
    .PID_insdata(PID_insdata), .duty(duty), .duty_vld(duty_vld), .busy(busy),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  // stimulus per cycle
  bit d_enc [NA], d_end [NA], d_clr [NA];
  logic [13:0] d_out [NA];
  logic [11:0] d_ins [NA];
  logic [11:0] rt_tab [NP+2];
  int npulse [NP];
  // expected strobes / model events per cycle
  bit e_start [NA], e_clr [NA], e_vld [NA], e_busy [NA];
  bit e_to [NA], e_ov [NA], e_eclr [NA], e_yts [NA], e_rts [NA], e_inss [NA];
  logic [11:0] e_dv [NA], e_ytv [NA], e_rtv [NA], e_insv [NA];

  logic [11:0] pduty = 0;
  logic [11:0] m_duty = 0, m_yt = 0, m_rt = 0, m_ins = 0;
  bit m_to = 0, m_ov = 0;
  int checks = 0, errors = 0;
  int last_vld = 0;
  int pin_d0 = -1, pin_d1 = -1, pin_d2 = -1, pin_ins = -1, pin_to = -1, pin_ov = -1;

  function automatic logic [11:0] sat(input logic [13:0] v);
    return (v > 14'd4095) ? 12'hFFF : v[11:0];
  endfunction

  function automatic logic [11:0] next_duty(input logic [11:0] cur, input logic [11:0] tgt);
`ifdef PID_DUTY_RAMP_EN
    if (int'(tgt) > int'(cur) + 64) return 12'(int'(cur) + 64);
    if (int'(tgt) < int'(cur) - 64) return 12'(int'(cur) - 64);
`endif
    return tgt;
  endfunction

  task automatic chk(input string nm, input int c, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic mark_busy(input int a, input int b);
    for (int i = a; i <= b; i++) e_busy[i] = 1;
  endtask

  // core answers w+d cycles into WAIT_END (w = first WAIT_END cycle),
  // holds PID_end for 'hold' cycles; f = first cycle PID_end is low again
  task automatic plan_resp(input int w, input logic [13:0] out, input int d,
                           input int hold, output int f);
    int e;
    e = w + d;
    for (int i = e; i < e + hold; i++) begin
      d_end[i] = 1;
      d_out[i] = out;
    end
    pduty = next_duty(pduty, sat(out));
    e_vld[e+2] = 1;
    e_dv[e+2]  = pduty;
    last_vld   = e + 2;
    f = e + hold;
  endtask

  task automatic plan_start(input int t, input int kind, input logic [13:0] out,
                            input int d, output int f);
    e_start[t+2] = 1;
    if (kind == K_TO) begin
      f = t + 2 + TO;
      e_to[f] = 1;
    end else begin
      plan_resp(t + 2, out, d, (kind == K_HOLD) ? 200 : 5, f);
    end
    mark_busy(t + 1, f);
  endtask

  // request at c, seen by an idle sequencer at s
  task automatic plan_clr(input int c, input int s, input logic [11:0] ins,
                          input int d, output int f);
    d_clr[c] = 1;
    d_ins[c] = ins;
    e_eclr[c+1] = 1;
    e_clr[s+1]  = 1;
    e_clr[s+2]  = 1;
    e_inss[s+1] = 1;
    e_insv[s+1] = ins;
    plan_resp(s + 3, {2'b00, ins}, d, 5, f);
    mark_busy(s + 1, f);
  endtask

  initial begin
    int t, f, f2, kind, d;
    logic [13:0] out;
    for (int i = 0; i < NA; i++) begin
      d_out[i] = 14'($urandom);
      d_ins[i] = 12'($urandom);
    end
    for (int p = 0; p < NP + 2; p++) rt_tab[p] = 12'($urandom);
    for (int p = 0; p < NP; p++) begin
      npulse[p] = (p == 0) ? 37 : int'($urandom_range(0, 38));
      for (int k = 0; k < npulse[p]; k++) begin
        d_enc[PER*p + 10 + 4*k]     = 1;
        d_enc[PER*p + 10 + 4*k + 1] = 1;
      end
    end

    for (int p = 0; p < NP; p++) begin
      t = PER * p + PER - 1;
      e_yts[t+1] = 1;
      e_ytv[t+1] = 12'(npulse[p]);
      kind = (p == 2) ? K_TO : (p == 3) ? K_HOLD : (p == 4) ? K_NONE :
             (p == 6) ? K_COINC : K_NORM;
      out = (p == 0) ? 14'd1000 : (p == 1) ? 14'h2ABC : 14'($urandom_range(0, 16383));
      d = (p == 0) ? 5 : int'($urandom_range(1, 30));
      f = 0;
      if (kind == K_COINC) begin
        plan_clr(t, t, 12'($urandom), int'($urandom_range(1, 30)), f);
        e_ov[t+1] = 1;
      end else if (e_busy[t]) begin
        e_ov[t+1] = 1;
        if (p == 4) pin_ov = t + 1;
      end else begin
        e_rts[t+1] = 1;
        e_rtv[t+1] = rt_tab[p];
        if (kind != K_NONE) plan_start(t, kind, out, d, f);
      end
      if (p == 0) pin_d0 = last_vld;
      if (p == 1) pin_d1 = last_vld;
      if (p == 2) pin_to = t + 2 + TO;
      if (p == 3) plan_clr(t + 50, f + 1, 12'($urandom), int'($urandom_range(1, 30)), f2);
      if (p == 0 || p == 2 || p == 5 || (p >= 7 && $urandom_range(0, 1) == 1)) begin
        plan_clr(t + 100, t + 100, (p == 0) ? 12'h400 : 12'($urandom),
                 int'($urandom_range(1, 30)), f2);
        if (p == 0) begin
          pin_ins = t + 101;
          pin_d2  = last_vld;
        end
      end
    end

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_start", -1, PID_start, 0);   chk("rst_clr", -1, PID_clr, 0);
    chk("rst_rt", -1, PID_rt, 0);         chk("rst_yt", -1, PID_yt, 0);
    chk("rst_ins", -1, PID_insdata, 0);   chk("rst_duty", -1, duty, 0);
    chk("rst_vld", -1, duty_vld, 0);      chk("rst_busy", -1, busy, 0);
    chk("rst_to", -1, timeout_err, 0);    chk("rst_ov", -1, overrun_err, 0);
    rst_n = 1;

    for (int c = 0; c <= NC; c++) begin
      if (c > 0) @(negedge clk);
      enc_a    = d_enc[c];
      PID_end  = d_end[c];
      PID_out  = d_out[c];
      clr_req  = d_clr[c];
      ins_data = d_ins[c];
      rt_set   = rt_tab[c / PER];
      // model update for this cycle
      if (e_eclr[c]) begin m_to = 0; m_ov = 0; end
      if (e_to[c]) m_to = 1;
      if (e_ov[c]) m_ov = 1;
      if (e_vld[c]) m_duty = e_dv[c];
      if (e_yts[c]) m_yt = e_ytv[c];
      if (e_rts[c]) m_rt = e_rtv[c];
      if (e_inss[c]) m_ins = e_insv[c];
      chk("PID_start", c, PID_start, e_start[c]);
      chk("PID_clr", c, PID_clr, e_clr[c]);
      chk("duty_vld", c, duty_vld, e_vld[c]);
      chk("busy", c, busy, e_busy[c]);
      chk("duty", c, duty, m_duty);
      chk("PID_yt", c, PID_yt, m_yt);
      chk("PID_rt", c, PID_rt, m_rt);
      chk("timeout_err", c, timeout_err, m_to);
      chk("overrun_err", c, overrun_err, m_ov);
      if (e_clr[c]) chk("PID_insdata", c, PID_insdata, m_ins);
      // hand-computed anchors
      if (c == PER) chk("pin_yt37", c, PID_yt, 12'd37);
      if (c == pin_to) chk("pin_timeout", c, timeout_err, 1);
      if (c == pin_ov) chk("pin_overrun", c, overrun_err, 1);
      if (c == pin_ins || c == pin_ins + 1) chk("pin_ins400", c, PID_insdata, 12'h400);
`ifndef PID_DUTY_RAMP_EN
      if (c == pin_d0) chk("pin_duty1000", c, duty, 12'd1000);
      if (c == pin_d1) chk("pin_dutysat", c, duty, 12'hFFF);
      if (c == pin_d2) chk("pin_duty400", c, duty, 12'h400);
`endif
    end

    // asynchronous reset in the middle of a clear sequence
    @(negedge clk);
    clr_req  = 1;
    ins_data = 12'h123;
    @(negedge clk);
    clr_req = 0;
    chk("mid_busy", NC + 2, busy, 1);
    chk("mid_clr", NC + 2, PID_clr, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", NC + 2, busy, 0);
    chk("arst_clr", NC + 2, PID_clr, 0);
    chk("arst_ins", NC + 2, PID_insdata, 0);
    chk("arst_duty", NC + 2, duty, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
